// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter with valid/ready input and framing strobes.
// Optional even-parity trailer bit when SER_TX_PARITY_EN is defined.
module serial_word_tx #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dir,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

`ifdef SER_TX_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(FLEN - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [FLEN-1:0] shreg_q, shreg_d;
    logic            ser_out_q, ser_out_d;
    logic            ser_valid_q, ser_valid_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d;

    logic [WIDTH-1:0] ordered;
    logic [FLEN-1:0]  frame;
    logic             last_bit;
    logic             accept;

    // Reorder the word so the frame always leaves from bit 0 of the shadow register.
    always_comb begin
        ordered = '0;
        for (int k = 0; k < WIDTH; k++) begin
            ordered[k] = in_dir ? in_data[WIDTH-1-k] : in_data[k];
        end
    end

`ifdef SER_TX_PARITY_EN
    assign frame = {^in_data, ordered};
`else
    assign frame = ordered;
`endif

    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign in_ready = (state_q == IDLE) || last_bit;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        if (accept) begin
            state_d       = SHIFT;
            cnt_d         = '0;
            ser_out_d     = frame[0];
            shreg_d       = frame >> 1;
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d     = IDLE;
                cnt_d       = '0;
                shreg_d     = '0;
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
            end else begin
                cnt_d        = cnt_q + CNTW'(1);
                ser_out_d    = shreg_q[0];
                shreg_d      = shreg_q >> 1;
                frame_done_d = (cnt_d == LAST_CNT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = ser_valid_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: directed scenarios plus a randomized scoreboard run.
// Honours SER_TX_PARITY_EN to expect the trailing even-parity bit.
module tb_serial_word_tx;

    localparam int WIDTH = 5;
`ifdef SER_TX_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             in_dir;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    int testsRun;
    int testsFailed;

    typedef struct packed {
        logic b;
        logic s;
        logic d;
    } expBit_t;

    expBit_t sbq[$];

    serial_word_tx #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dir     (in_dir),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame bit k of a word: data bits in the chosen order, then the even-parity trailer.
    function automatic logic modelBit(logic [WIDTH-1:0] d, logic dir, int k);
        if (k >= WIDTH) return ^d;
        return dir ? d[WIDTH-1-k] : d[k];
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_dir   = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if ({in_ready, ser_valid, ser_out, busy} !== 4'b1000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %b expected 1000", {in_ready, ser_valid, ser_out, busy});
        end
        testsRun++;
        if ({frame_start, frame_done} !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got %b expected 00", {frame_start, frame_done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if ({in_ready, ser_valid} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_idle: got %b expected 10", {in_ready, ser_valid});
        end
    endtask

    task automatic test_lsb_first();
        logic [WIDTH-1:0] w;
        logic [3:0] expv;
        w = 5'b10110;
        @(negedge clk);
        in_data = w; in_dir = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        for (int k = 0; k < FLEN; k++) begin
            expv = {1'b1, modelBit(w, 1'b0, k), k == 0, k == FLEN - 1};
            testsRun++;
            if ({ser_valid, ser_out, frame_start, frame_done} !== expv) begin
                testsFailed++;
                $display("[TB] FAIL lsb_bit%0d: got %b expected %b", k, {ser_valid, ser_out, frame_start, frame_done}, expv);
            end
            @(negedge clk);
        end
        testsRun++;
        if ({ser_valid, ser_out, in_ready, frame_done} !== 4'b0010) begin
            testsFailed++;
            $display("[TB] FAIL lsb_after_idle: got %b expected 0010", {ser_valid, ser_out, in_ready, frame_done});
        end
    endtask

    task automatic test_msb_first_ignore_busy();
        logic [WIDTH-1:0] w;
        logic [3:0] expv;
        w = 5'b10110;
        in_data = w; in_dir = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_dir   = 1'b0;
        for (int k = 0; k < FLEN; k++) begin
            expv = {1'b1, modelBit(w, 1'b1, k), k == 0, k == FLEN - 1};
            testsRun++;
            if ({ser_valid, ser_out, frame_start, frame_done} !== expv) begin
                testsFailed++;
                $display("[TB] FAIL msb_bit%0d: got %b expected %b", k, {ser_valid, ser_out, frame_start, frame_done}, expv);
            end
            if (k == 2) begin
                in_valid = 1'b1;
                in_data  = '0;
                testsRun++;
                if (in_ready !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL msb_busy_ready: got %b expected 0", in_ready);
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        testsRun++;
        if ({ser_valid, in_ready} !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL msb_word_not_consumed: got %b expected 01", {ser_valid, in_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d;
        logic [4:0] expv;
        int starts, dones, k;
        starts = 0; dones = 0;
        in_data = 5'b11111; in_dir = 1'b0; in_valid = 1'b1;
        for (int j = 0; j < 2 * FLEN; j++) begin
            @(negedge clk);
            k = j % FLEN;
            d = (j < FLEN) ? 5'b11111 : 5'b00001;
            expv = {1'b1, modelBit(d, 1'b0, k), k == 0, k == FLEN - 1, k == FLEN - 1};
            testsRun++;
            if ({ser_valid, ser_out, frame_start, frame_done, in_ready} !== expv) begin
                testsFailed++;
                $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", j, {ser_valid, ser_out, frame_start, frame_done, in_ready}, expv);
            end
            starts += int'(frame_start);
            dones  += int'(frame_done);
            if (j == 0) in_data = 5'b00001;
            if (j == FLEN) in_valid = 1'b0;
        end
        @(negedge clk);
        testsRun++;
        if ({ser_valid, in_ready} !== 2'b01 || starts != 2 || dones != 2) begin
            testsFailed++;
            $display("[TB] FAIL b2b_counts: got valid=%b starts=%0d dones=%0d expected valid=0 starts=2 dones=2", ser_valid, starts, dones);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [WIDTH-1:0] w;
        logic [3:0] expv;
        int dones;
        w = 5'b10101;
        in_data = w; in_dir = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if ({ser_valid, ser_out} !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL midrst_before: got %b expected 11", {ser_valid, ser_out});
        end
        #2 rst_n = 1'b0;
        #1;
        testsRun++;
        if ({ser_valid, ser_out, busy, frame_done, in_ready} !== 5'b00001) begin
            testsFailed++;
            $display("[TB] FAIL midrst_async_drop: got %b expected 00001", {ser_valid, ser_out, busy, frame_done, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (FLEN) begin
            @(negedge clk);
            dones += int'(frame_done) + int'(ser_valid);
        end
        testsRun++;
        if (dones != 0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_no_completion: got %0d stray strobe cycles expected 0", dones);
        end
        w = 5'b00011;
        in_data = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < FLEN; k++) begin
            expv = {1'b1, modelBit(w, 1'b0, k), k == 0, k == FLEN - 1};
            testsRun++;
            if ({ser_valid, ser_out, frame_start, frame_done} !== expv) begin
                testsFailed++;
                $display("[TB] FAIL midrst_next_bit%0d: got %b expected %b", k, {ser_valid, ser_out, frame_start, frame_done}, expv);
            end
            @(negedge clk);
        end
    endtask

`ifdef SER_TX_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] words [2];
        logic             par [2];
        words[0] = 5'b10110; par[0] = 1'b1;
        words[1] = 5'b00011; par[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_data = words[i]; in_dir = 1'(i); in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (WIDTH) @(negedge clk);
            testsRun++;
            if ({ser_valid, ser_out, frame_done} !== {1'b1, par[i], 1'b1}) begin
                testsFailed++;
                $display("[TB] FAIL parity_word%0d: got %b expected %b", i, {ser_valid, ser_out, frame_done}, {1'b1, par[i], 1'b1});
            end
        end
        @(negedge clk);
    endtask
`endif

    // Scoreboard: each accepted word enqueues its frame; each cycle pops what the line must show.
    task automatic test_random();
        expBit_t e;
        logic rdy;
        logic [5:0] expv, obsv;
        int errs;
        errs = 0;
        sbq.delete();
        for (int cyc = 0; cyc < 400 + FLEN + 2; cyc++) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                expv = {1'b0, 1'b1, 1'b1, e.b, e.s, e.d};
            end else begin
                expv = '0;
            end
            rdy = (sbq.size() == 0);
            expv[5] = rdy;
            obsv = {in_ready, ser_valid, busy, ser_out, frame_start, frame_done};
            testsRun++;
            if (obsv !== expv) begin
                testsFailed++;
                errs++;
                if (errs <= 10)
                    $display("[TB] FAIL random_cycle%0d: got %b expected %b", cyc, obsv, expv);
            end
            in_valid = (cyc < 400) && ($urandom_range(0, 2) != 0);
            in_data  = WIDTH'($urandom);
            in_dir   = 1'($urandom);
            if (in_valid && rdy) begin
                for (int k = 0; k < FLEN; k++) begin
                    e.b = modelBit(in_data, in_dir, k);
                    e.s = (k == 0);
                    e.d = (k == FLEN - 1);
                    sbq.push_back(e);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        test_reset();
        test_lsb_first();
        test_msb_first_ignore_busy();
        test_back_to_back();
        test_mid_frame_reset();
`ifdef SER_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
